tdp_ram_pipe: RTL and testbench



---
 rtl/tdp_ram_pkg.sv | 25 ++
 rtl/tdp_ram_rd_pipe.sv | 65 ++++++
 rtl/tdp_ram_pipe.sv | 205 ++++++++++++++++++++
 tb/tb_tdp_ram_pipe.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tdp_ram_pkg.sv
// ---------------------------------------------------------------------------
// tdp_ram_pkg
// Shared definitions for the true-dual-port RAM with read pipeline:
//   - WRITE_MODE encodings for same-port read-during-write behaviour
//   - legal READ_LATENCY values
//   - controller state enum (CLEAR sweeps the array to zero, RUN serves ports)
// No ports (package).
// ---------------------------------------------------------------------------
package tdp_ram_pkg;

    // Same-port read-during-write behaviour
    localparam int WM_READ_FIRST  = 0;
    localparam int WM_WRITE_FIRST = 1;
    localparam int WM_NO_CHANGE   = 2;

    // Legal read pipeline depths
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/tdp_ram_rd_pipe.sv
// ---------------------------------------------------------------------------
// tdp_ram_rd_pipe
// Read data/valid pipeline for one RAM port. Stage 1 captures the word
// selected on the sampling edge; with LATENCY=2 a second output register
// follows. Data registers only load on a valid beat, so the output holds its
// last value between reads. Valid bits are cleared by reset, which flushes
// any read in flight.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_data   read issued this cycle and the word it returns
//   out_valid, out_data delayed strobe and held read word
// ---------------------------------------------------------------------------
module tdp_ram_rd_pipe
    import tdp_ram_pkg::*;
#(
    parameter int WIDTH   = 18,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= in_data;
            end
        end
    end

    if (LATENCY == RD_LAT_MIN) begin : g_lat1
        assign out_valid = s1_valid;
        assign out_data  = s1_data;
    end else begin : g_lat2
        logic             s2_valid;
        logic [WIDTH-1:0] s2_data;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_valid <= 1'b0;
                s2_data  <= '0;
            end else begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= s1_data;
                end
            end
        end

        assign out_valid = s2_valid;
        assign out_data  = s2_data;
    end

endmodule

// File: rtl/tdp_ram_pipe.sv
// ---------------------------------------------------------------------------
// tdp_ram_pipe
// True-dual-port RAM, single clock, DEPTH words of DATA_WIDTH data bits plus
// one parity bit per byte. After reset (or FLUSH) the array is swept to zero
// one address per cycle while BUSY is high; port requests are ignored then.
// Ports:
//   CLK, RST_N            clock, asynchronous active-low reset
//   WEN_x, REN_x          write / read enable for port A and B
//   BE_x                  byte write enables
//   ADDR_x                word address
//   WDATA_x, WPARITY_x    write data and per-byte parity
//   RDATA_x, RPARITY_x    read data and parity (held between reads)
//   RVALID_x              one-cycle strobe READ_LATENCY cycles after a read
//   FLUSH                 start a full clear (only honoured in RUN)
//   BUSY                  clear in progress
//   COLLISION             pulse the cycle after both ports wrote one address
// ---------------------------------------------------------------------------
module tdp_ram_pipe
    import tdp_ram_pkg::*;
#(
    parameter  int DATA_WIDTH   = 16,
    parameter  int DEPTH        = 1024,
    parameter  int READ_LATENCY = 1,
    parameter  int WRITE_MODE   = 0,
    localparam int NB           = DATA_WIDTH / 8,
    localparam int AW           = $clog2(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  WEN_A,
    input  logic                  REN_A,
    input  logic [NB-1:0]         BE_A,
    input  logic [AW-1:0]         ADDR_A,
    input  logic [DATA_WIDTH-1:0] WDATA_A,
    input  logic [NB-1:0]         WPARITY_A,
    output logic [DATA_WIDTH-1:0] RDATA_A,
    output logic [NB-1:0]         RPARITY_A,
    output logic                  RVALID_A,
    input  logic                  WEN_B,
    input  logic                  REN_B,
    input  logic [NB-1:0]         BE_B,
    input  logic [AW-1:0]         ADDR_B,
    input  logic [DATA_WIDTH-1:0] WDATA_B,
    input  logic [NB-1:0]         WPARITY_B,
    output logic [DATA_WIDTH-1:0] RDATA_B,
    output logic [NB-1:0]         RPARITY_B,
    output logic                  RVALID_B,
    input  logic                  FLUSH,
    output logic                  BUSY,
    output logic                  COLLISION
);

    // Stored word layout: {parity[NB-1:0], data[DATA_WIDTH-1:0]}
    localparam int WW = DATA_WIDTH + NB;

    state_t          state;
    state_t          state_next;
    logic [AW-1:0]   clr_addr;
    logic [AW-1:0]   clr_addr_next;
    logic            run;
    logic            collision_q;

    logic [WW-1:0]   mem [DEPTH];

    logic [WW-1:0]   old_a;
    logic [WW-1:0]   old_b;
    logic [WW-1:0]   rd_word_a;
    logic [WW-1:0]   rd_word_b;
    logic            rd_fire_a;
    logic            rd_fire_b;
    logic [WW-1:0]   rd_out_a;
    logic [WW-1:0]   rd_out_b;

    // Overlay the enabled bytes (data and parity) of a write onto an old word
    function automatic logic [WW-1:0] merge_word(
        input logic [WW-1:0]         old,
        input logic [DATA_WIDTH-1:0] wd,
        input logic [NB-1:0]         wp,
        input logic [NB-1:0]         be
    );
        logic [WW-1:0] r;
        r = old;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                r[8*i +: 8]       = wd[8*i +: 8];
                r[DATA_WIDTH + i] = wp[i];
            end
        end
        return r;
    endfunction

    assign run  = (state == ST_RUN);
    assign BUSY = (state == ST_CLEAR);

    // Controller state and clear-address counter
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
        end else begin
            state    <= state_next;
            clr_addr <= clr_addr_next;
        end
    end

    // CLEAR walks every address once, then hands over to RUN. The counter
    // wraps back to zero on the last address because DEPTH is a power of two.
    always_comb begin
        state_next    = state;
        clr_addr_next = clr_addr;
        case (state)
            ST_CLEAR: begin
                clr_addr_next = clr_addr + 1'b1;
                if (clr_addr == AW'(DEPTH - 1)) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (FLUSH) begin
                    state_next    = ST_CLEAR;
                    clr_addr_next = '0;
                end
            end
            default: begin
                state_next    = ST_CLEAR;
                clr_addr_next = '0;
            end
        endcase
    end

    // Memory array, deliberately without reset. Port B's bytes are scheduled
    // before port A's so that on a same-address clash A wins the bytes both
    // ports enable while B-only bytes still land.
    always_ff @(posedge CLK) begin
        if (state == ST_CLEAR) begin
            mem[clr_addr] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (WEN_B && BE_B[i]) begin
                    mem[ADDR_B][8*i +: 8]       <= WDATA_B[8*i +: 8];
                    mem[ADDR_B][DATA_WIDTH + i] <= WPARITY_B[i];
                end
                if (WEN_A && BE_A[i]) begin
                    mem[ADDR_A][8*i +: 8]       <= WDATA_A[8*i +: 8];
                    mem[ADDR_A][DATA_WIDTH + i] <= WPARITY_A[i];
                end
            end
        end
    end

    // Read word selection: the array is sampled before this edge's writes,
    // so reads see old data unless write-first merges the port's own write.
    // Writes from the other port are never forwarded.
    assign old_a = mem[ADDR_A];
    assign old_b = mem[ADDR_B];

    assign rd_word_a = (WRITE_MODE == WM_WRITE_FIRST && WEN_A) ?
                       merge_word(old_a, WDATA_A, WPARITY_A, BE_A) : old_a;
    assign rd_word_b = (WRITE_MODE == WM_WRITE_FIRST && WEN_B) ?
                       merge_word(old_b, WDATA_B, WPARITY_B, BE_B) : old_b;

    assign rd_fire_a = run && REN_A && !(WRITE_MODE == WM_NO_CHANGE && WEN_A);
    assign rd_fire_b = run && REN_B && !(WRITE_MODE == WM_NO_CHANGE && WEN_B);

    tdp_ram_rd_pipe #(
        .WIDTH   (WW),
        .LATENCY (READ_LATENCY)
    ) u_rd_pipe_a (
        .clk       (CLK),
        .rst_n     (RST_N),
        .in_valid  (rd_fire_a),
        .in_data   (rd_word_a),
        .out_valid (RVALID_A),
        .out_data  (rd_out_a)
    );

    tdp_ram_rd_pipe #(
        .WIDTH   (WW),
        .LATENCY (READ_LATENCY)
    ) u_rd_pipe_b (
        .clk       (CLK),
        .rst_n     (RST_N),
        .in_valid  (rd_fire_b),
        .in_data   (rd_word_b),
        .out_valid (RVALID_B),
        .out_data  (rd_out_b)
    );

    assign RDATA_A   = rd_out_a[DATA_WIDTH-1:0];
    assign RPARITY_A = rd_out_a[WW-1:DATA_WIDTH];
    assign RDATA_B   = rd_out_b[DATA_WIDTH-1:0];
    assign RPARITY_B = rd_out_b[WW-1:DATA_WIDTH];

    // Same-address write clash, reported one cycle later
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            collision_q <= 1'b0;
        end else begin
            collision_q <= run && WEN_A && WEN_B && (ADDR_A == ADDR_B);
        end
    end

    assign COLLISION = collision_q;

endmodule

// File: tb/tb_tdp_ram_pipe.sv
// ---------------------------------------------------------------------------
// tb_tdp_ram_pipe
// Directed bench for tdp_ram_pipe with DEPTH=16. Four instances share the
// same stimulus so the mode/latency variants can be compared side by side:
//   0: read-first,  latency 1
//   1: write-first, latency 2
//   2: read-first,  latency 2
//   3: no-change,   latency 1
// ---------------------------------------------------------------------------
module tb_tdp_ram_pipe;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        wen_a, ren_a, wen_b, ren_b;
    logic [1:0]  be_a, be_b, wpar_a, wpar_b;
    logic [3:0]  addr_a, addr_b;
    logic [15:0] wdata_a, wdata_b;

    logic [15:0] rdata_a   [4];
    logic [15:0] rdata_b   [4];
    logic [1:0]  rparity_a [4];
    logic [1:0]  rparity_b [4];
    logic [3:0]  rvalid_a, rvalid_b, busy, collision;

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        tdp_ram_pipe #(
            .DATA_WIDTH   (16),
            .DEPTH        (16),
            .READ_LATENCY ((g == 1 || g == 2) ? 2 : 1),
            .WRITE_MODE   ((g == 1) ? 1 : ((g == 3) ? 2 : 0))
        ) u_dut (
            .CLK       (clk),
            .RST_N     (rst_n),
            .WEN_A     (wen_a),
            .REN_A     (ren_a),
            .BE_A      (be_a),
            .ADDR_A    (addr_a),
            .WDATA_A   (wdata_a),
            .WPARITY_A (wpar_a),
            .RDATA_A   (rdata_a[g]),
            .RPARITY_A (rparity_a[g]),
            .RVALID_A  (rvalid_a[g]),
            .WEN_B     (wen_b),
            .REN_B     (ren_b),
            .BE_B      (be_b),
            .ADDR_B    (addr_b),
            .WDATA_B   (wdata_b),
            .WPARITY_B (wpar_b),
            .RDATA_B   (rdata_b[g]),
            .RPARITY_B (rparity_b[g]),
            .RVALID_B  (rvalid_b[g]),
            .FLUSH     (flush),
            .BUSY      (busy[g]),
            .COLLISION (collision[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something stalls far beyond the expected run length
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic setIdle();
        wen_a = 1'b0; ren_a = 1'b0; be_a = 2'b00; addr_a = 4'd0; wdata_a = 16'h0; wpar_a = 2'b00;
        wen_b = 1'b0; ren_b = 1'b0; be_b = 2'b00; addr_b = 4'd0; wdata_b = 16'h0; wpar_b = 2'b00;
    endtask

    // Drive both ports for exactly one clock edge, then return to idle
    task automatic applyStimulus(
        input logic wa, input logic ra, input logic [1:0] bea, input logic [3:0] aa,
        input logic [15:0] da, input logic [1:0] pa,
        input logic wb, input logic rb, input logic [1:0] beb, input logic [3:0] ab,
        input logic [15:0] db, input logic [1:0] pb
    );
        wen_a = wa; ren_a = ra; be_a = bea; addr_a = aa; wdata_a = da; wpar_a = pa;
        wen_b = wb; ren_b = rb; be_b = beb; addr_b = ab; wdata_b = db; wpar_b = pb;
        tick();
        setIdle();
    endtask

    // Count edges until BUSY drops on instance 0, bounded
    task automatic waitBusyLow(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (busy[0] && n < 100);
    endtask

    initial begin
        int n;
        int spurious;

        rst_n = 1'b0;
        flush = 1'b0;
        setIdle();

        // Reset state
        tick();
        tick();
        checkOutput("rst_busy", busy, 4'hF);
        checkOutput("rst_rvalid", {rvalid_a, rvalid_b}, 8'h00);
        checkOutput("rst_collision", collision, 4'h0);
        checkOutput("rst_rdata", {rdata_a[0], rdata_b[0], rparity_a[0], rparity_b[0]}, 36'h0);

        // Clear after reset release lasts DEPTH cycles
        rst_n = 1'b1;
        waitBusyLow(n);
        checkOutput("clear_len", n, 16);
        checkOutput("clear_all_done", busy, 4'h0);

        // Cleared word reads zero one cycle later
        applyStimulus(0, 1, 2'b00, 4'd5, 16'h0, 2'b00, 0, 0, 2'b00, 4'd0, 16'h0, 2'b00);
        checkOutput("rd5_l1", {rvalid_a[0], rparity_a[0], rdata_a[0]}, {1'b1, 2'b00, 16'h0000});
        checkOutput("rd5_l2_early", rvalid_a[1], 1'b0);
        tick();
        checkOutput("rd5_l1_pulse", rvalid_a[0], 1'b0);
        checkOutput("rd5_l2", {rvalid_a[1], rdata_a[1]}, {1'b1, 16'h0000});

        // Byte-enabled writes
        applyStimulus(1, 0, 2'b01, 4'd3, 16'hBEEF, 2'b10, 0, 0, 2'b00, 4'd0, 16'h0, 2'b00);
        applyStimulus(0, 0, 2'b00, 4'd0, 16'h0, 2'b00, 0, 1, 2'b00, 4'd3, 16'h0, 2'b00);
        checkOutput("be_lo", {rvalid_b[0], rparity_b[0], rdata_b[0]}, {1'b1, 2'b00, 16'h00EF});
        applyStimulus(1, 0, 2'b10, 4'd3, 16'h1234, 2'b11, 0, 0, 2'b00, 4'd0, 16'h0, 2'b00);
        applyStimulus(0, 0, 2'b00, 4'd0, 16'h0, 2'b00, 0, 1, 2'b00, 4'd3, 16'h0, 2'b00);
        checkOutput("be_hi", {rvalid_b[0], rparity_b[0], rdata_b[0]}, {1'b1, 2'b10, 16'h12EF});

        // Full write-write clash at address 7
        applyStimulus(1, 0, 2'b11, 4'd7, 16'h1111, 2'b00, 1, 0, 2'b11, 4'd7, 16'h2222, 2'b11);
        checkOutput("coll_pulse", collision, 4'hF);
        tick();
        checkOutput("coll_once", collision, 4'h0);
        applyStimulus(0, 1, 2'b00, 4'd7, 16'h0, 2'b00, 0, 0, 2'b00, 4'd0, 16'h0, 2'b00);
        checkOutput("coll_a_wins", {rparity_a[0], rdata_a[0]}, {2'b00, 16'h1111});

        // Partial clash: A owns byte 0, byte 1 only from B
        applyStimulus(1, 0, 2'b01, 4'd8, 16'hAA44, 2'b01, 1, 0, 2'b11, 4'd8, 16'h55BB, 2'b10);
        checkOutput("coll_part_pulse", collision[0], 1'b1);
        applyStimulus(0, 1, 2'b00, 4'd8, 16'h0, 2'b00, 0, 0, 2'b00, 4'd0, 16'h0, 2'b00);
        checkOutput("coll_part_merge", {rparity_a[0], rdata_a[0]}, {2'b11, 16'h5544});

        // Writes to different addresses are not a clash
        applyStimulus(1, 0, 2'b11, 4'd9, 16'h9999, 2'b00, 1, 0, 2'b11, 4'd10, 16'hA0A0, 2'b00);
        checkOutput("no_coll_diff", collision[0], 1'b0);

        // Cross-port write/read: reader sees old data, no clash
        applyStimulus(1, 0, 2'b11, 4'd7, 16'h7777, 2'b01, 0, 1, 2'b00, 4'd7, 16'h0, 2'b00);
        checkOutput("xport_old", {rvalid_b[0], rdata_b[0]}, {1'b1, 16'h1111});
        checkOutput("no_coll_wr_rd", collision[0], 1'b0);
        applyStimulus(0, 1, 2'b00, 4'd7, 16'h0, 2'b00, 0, 0, 2'b00, 4'd0, 16'h0, 2'b00);
        checkOutput("xport_new", {rparity_a[0], rdata_a[0]}, {2'b01, 16'h7777});

        // Same-port read during write at address 2 (old 0x5555)
        applyStimulus(1, 0, 2'b11, 4'd2, 16'h5555, 2'b00, 0, 0, 2'b00, 4'd0, 16'h0, 2'b00);
        applyStimulus(1, 1, 2'b11, 4'd2, 16'hAAAA, 2'b00, 0, 0, 2'b00, 4'd0, 16'h0, 2'b00);
        checkOutput("rf_l1", {rvalid_a[0], rdata_a[0]}, {1'b1, 16'h5555});
        checkOutput("nc_hold", {rvalid_a[3], rdata_a[3]}, {1'b0, 16'h7777});
        checkOutput("wf_l2_early", rvalid_a[1], 1'b0);
        tick();
        checkOutput("wf_l2", {rvalid_a[1], rdata_a[1]}, {1'b1, 16'hAAAA});
        checkOutput("rf_l2", {rvalid_a[2], rdata_a[2]}, {1'b1, 16'h5555});
        checkOutput("nc_written", rdata_a[3], 16'h7777);

        // Back-to-back reads through the two-stage pipeline
        applyStimulus(0, 1, 2'b00, 4'd2, 16'h0, 2'b00, 0, 0, 2'b00, 4'd0, 16'h0, 2'b00);
        checkOutput("b2b_l1_0", rdata_a[0], 16'hAAAA);
        applyStimulus(0, 1, 2'b00, 4'd3, 16'h0, 2'b00, 0, 0, 2'b00, 4'd0, 16'h0, 2'b00);
        checkOutput("b2b_l1_1", {rvalid_a[0], rdata_a[0]}, {1'b1, 16'h12EF});
        checkOutput("b2b_l2_0", {rvalid_a[1], rdata_a[1]}, {1'b1, 16'hAAAA});
        tick();
        checkOutput("b2b_l2_1", {rvalid_a[1], rdata_a[1]}, {1'b1, 16'h12EF});
        tick();
        checkOutput("b2b_l2_end", {rvalid_a[1], rdata_a[1]}, {1'b0, 16'h12EF});

        // FLUSH in RUN; requests and a held FLUSH are ignored while clearing
        checkOutput("pre_flush_busy", busy[0], 1'b0);
        flush = 1'b1;
        tick();
        checkOutput("flush_busy", busy, 4'hF);
        spurious = 0;
        n = 0;
        wen_a = 1'b1; ren_a = 1'b1; be_a = 2'b11; addr_a = 4'd4; wdata_a = 16'hFFFF; wpar_a = 2'b11;
        wen_b = 1'b1; ren_b = 1'b1; be_b = 2'b11; addr_b = 4'd4; wdata_b = 16'h0F0F; wpar_b = 2'b11;
        do begin
            tick();
            n++;
            if (rvalid_a[0] || rvalid_b[0] || collision[0]) spurious++;
        end while (busy[0] && n < 100);
        setIdle();
        flush = 1'b0;
        checkOutput("flush_len", n, 16);
        checkOutput("flush_ignored", spurious, 0);
        checkOutput("flush_hold", {rdata_a[0], rdata_b[0]}, {16'h12EF, 16'h1111});

        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 1, 2'b00, 4'(i), 16'h0, 2'b00, 0, 1, 2'b00, 4'(15 - i), 16'h0, 2'b00);
            checkOutput($sformatf("flush_rd_a%0d", i), {rvalid_a[0], rparity_a[0], rdata_a[0]}, {1'b1, 18'h0});
            checkOutput($sformatf("flush_rd_b%0d", 15 - i), {rvalid_b[0], rparity_b[0], rdata_b[0]}, {1'b1, 18'h0});
        end

        // Reset in the middle of a clear (clear address 9)
        applyStimulus(1, 0, 2'b11, 4'd1, 16'h00C3, 2'b01, 0, 0, 2'b00, 4'd0, 16'h0, 2'b00);
        applyStimulus(0, 1, 2'b00, 4'd1, 16'h0, 2'b00, 0, 0, 2'b00, 4'd0, 16'h0, 2'b00);
        checkOutput("pre_rst_rd", rdata_a[0], 16'h00C3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        checkOutput("mid_clear_busy", busy[0], 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_rdata", {rdata_a[0], rdata_a[1], rparity_a[0], rparity_a[1]}, 36'h0);
        checkOutput("mid_rst_rvalid", {rvalid_a, rvalid_b}, 8'h00);
        checkOutput("mid_rst_busy", busy, 4'hF);
        tick();
        rst_n = 1'b1;
        waitBusyLow(n);
        checkOutput("mid_rst_len", n, 16);
        applyStimulus(0, 1, 2'b00, 4'd1, 16'h0, 2'b00, 0, 1, 2'b00, 4'd12, 16'h0, 2'b00);
        checkOutput("post_rst_rd", {rvalid_a[0], rdata_a[0], rvalid_b[0], rdata_b[0]}, {1'b1, 16'h0, 1'b1, 16'h0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
